apb_master_bridge: RTL

Converts a simple valid/ready request channel into APB4 initiator transactions and returns the completion on a valid/ready response channel. It sits upstream of the APB address decoders and connectors and is the single master of an `apb_intf` segment, for example the SPI core / DMA register space, when driven from the DMA or debug path. A watchdog aborts transfers whose slave never asserts `pready`. Exactly one transaction is outstanding at a time.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_intf.sv | 29 ++
 rtl/apb_wdt_cnt.sv | 29 ++
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, pprot bit positions and the
// default watchdog limit used by APB initiators.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  localparam logic [2:0] APB_PROT_PRIV  = 3'b001;
  localparam logic [2:0] APB_PROT_NSEC  = 3'b010;
  localparam logic [2:0] APB_PROT_INSTR = 3'b100;

  localparam int APB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/apb_intf.sv
// APB4 bus segment: one initiator (master modport) talking to one or more
// completers through decoders (slave modport).
interface apb_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    psel;
  logic                    penable;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pwrite;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;
  logic                    pready;

  modport master (
    output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    input  prdata, pslverr, pready
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
    output prdata, pslverr, pready
  );

endinterface

// File: rtl/apb_wdt_cnt.sv
// Clear/enable saturating wait-state counter; expired flags the cycle in which
// the LIMIT-th consecutive wait is being counted. LIMIT = 0 disables it.
module apb_wdt_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW      = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam bit            ENABLED = (LIMIT > 0);
  localparam logic [CW-1:0] LAST    = ENABLED ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (ENABLED && en && (count_reg != '1)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = ENABLED && (count_reg == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns one valid/ready request into a SETUP/ACCESS transfer
// and returns read data and error status on a valid/ready response channel.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  apb_intf.master                 m_apb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  apb_mst_state_e state_reg, state_next;

  logic accept, capture, abort;
  logic wdt_clr, wdt_en, wdt_expired;

  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [STRB_WIDTH-1:0] pstrb_reg;
  logic [2:0]            pprot_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_slverr_reg;
  logic                  rsp_timeout_reg;
  logic [STRB_WIDTH-1:0] strb_masked;

  // Reads never carry byte strobes onto the bus.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
      assign strb_masked[gi] = req_strb[gi] & req_write;
    end
  endgenerate

  apb_wdt_cnt #(
    .LIMIT   (TIMEOUT)
  ) u_wdt (
    .clk     (clk),
    .srst    (srst),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_expired)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    wdt_clr    = 1'b0;
    wdt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        wdt_clr    = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        // A late pready still completes normally even on the expiry cycle.
        if (m_apb.pready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          wdt_en = 1'b1;
          if (wdt_expired) begin
            abort      = 1'b1;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      paddr_reg       <= '0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      pstrb_reg       <= '0;
      pprot_reg       <= '0;
      rsp_rdata_reg   <= '0;
      rsp_slverr_reg  <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (accept) begin
        paddr_reg  <= req_addr;
        pwrite_reg <= req_write;
        pwdata_reg <= req_wdata;
        pstrb_reg  <= strb_masked;
        pprot_reg  <= req_prot;
      end
      if (capture) begin
        rsp_rdata_reg   <= pwrite_reg ? '0 : m_apb.prdata;
        rsp_slverr_reg  <= m_apb.pslverr;
        rsp_timeout_reg <= 1'b0;
      end else if (abort) begin
        rsp_rdata_reg   <= '0;
        rsp_slverr_reg  <= 1'b1;
        rsp_timeout_reg <= 1'b1;
      end
    end
  end

  assign req_ready     = (state_reg == IDLE) && !srst;
  assign rsp_valid     = (state_reg == RESP);
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_slverr    = rsp_slverr_reg;
  assign rsp_timeout   = rsp_timeout_reg;

  assign m_apb.psel    = (state_reg == SETUP) || (state_reg == ACCESS);
  assign m_apb.penable = (state_reg == ACCESS);
  assign m_apb.paddr   = paddr_reg;
  assign m_apb.pwrite  = pwrite_reg;
  assign m_apb.pwdata  = pwdata_reg;
  assign m_apb.pstrb   = pstrb_reg;
  assign m_apb.pprot   = pprot_reg;

endmodule
